// File: rtl/rps_tree_arbiter_if.sv
// Handshake bundle between requesting masters and the rotating-priority arbiter.
interface rps_tree_arbiter_if #(
  parameter int unsigned NUM_REQ = 8
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic               en;
  logic               lock;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic               valid;
  logic               req_up;
  logic [IDW-1:0]     count;

  modport master (
    output req, en, lock,
    input  gnt, gnt_id, valid, req_up, count
  );

  modport slave (
    input  req, en, lock,
    output gnt, gnt_id, valid, req_up, count
  );
endinterface

// File: rtl/rps_tree_arbiter.sv
// N-way rotating-priority arbiter with grant lock; one-cycle registered grant,
// pointer either free-running (MODE 0) or moving past the last winner (MODE 1).
module rps_tree_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned MODE    = 0
) (
  input  logic                clock,
  input  logic                reset,
  rps_tree_arbiter_if.slave   bus
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               valid_q, valid_d;

  logic [NUM_REQ-1:0] rot_c;
  logic [IDW-1:0]     off_c;
  logic [IDW-1:0]     win_c;
  logic               any_c;
  logic               hold_c;

  // Rotate requests so the pointer line sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot_c = '0;
    off_c = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rot_c[i] = bus.req[IDW'(ptr_q + IDW'(i))];
    end
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (rot_c[i]) off_c = IDW'(i);
    end
    win_c  = IDW'(ptr_q + off_c);
    any_c  = |bus.req;
    hold_c = valid_q & bus.lock & bus.req[gnt_id_q];
  end

  // Next-state: disable beats hold, hold beats fresh arbitration.
  always_comb begin
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    if (!bus.en) begin
      gnt_d    = '0;
      gnt_id_d = '0;
      valid_d  = 1'b0;
      if (MODE == 0) ptr_d = IDW'(ptr_q + IDW'(1));
    end else if (hold_c) begin
      ptr_d = ptr_q;
    end else if (any_c) begin
      gnt_d    = NUM_REQ'(1) << win_c;
      gnt_id_d = win_c;
      valid_d  = 1'b1;
      ptr_d    = (MODE == 0) ? IDW'(ptr_q + IDW'(1)) : IDW'(win_c + IDW'(1));
    end else begin
      gnt_d    = '0;
      gnt_id_d = '0;
      valid_d  = 1'b0;
      if (MODE == 0) ptr_d = IDW'(ptr_q + IDW'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q    <= '0;
      gnt_id_q <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= '0;
    end else begin
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.valid  = valid_q;
  assign bus.count  = ptr_q;
  assign bus.req_up = |bus.req;
endmodule

// File: tb/tb_rps_tree_arbiter.sv
// Bench for rps_tree_arbiter: directed 4-way scenarios in both modes plus
// random 2-way and 16-way traffic, all tracked by a behavioural model.
module tb_rps_tree_arbiter;
  typedef struct packed {
    int ptr;
    int id;
    bit vld;
  } mst_t;

  bit clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst;
  logic [3:0]  r0, r1;
  logic [1:0]  r2;
  logic [15:0] r3;
  logic        en0, en1, en2, en3;
  logic        lk0, lk1, lk2, lk3;
  bit          armed = 1'b0;
  int          total = 0;
  int          bad   = 0;

  mst_t ms0 = '0, ms1 = '0, ms2 = '0, ms3 = '0;

  rps_tree_arbiter_if #(.NUM_REQ(4))  if_a ();
  rps_tree_arbiter_if #(.NUM_REQ(4))  if_b ();
  rps_tree_arbiter_if #(.NUM_REQ(2))  if_c ();
  rps_tree_arbiter_if #(.NUM_REQ(16)) if_d ();

  assign if_a.req = r0;  assign if_a.en = en0; assign if_a.lock = lk0;
  assign if_b.req = r1;  assign if_b.en = en1; assign if_b.lock = lk1;
  assign if_c.req = r2;  assign if_c.en = en2; assign if_c.lock = lk2;
  assign if_d.req = r3;  assign if_d.en = en3; assign if_d.lock = lk3;

  rps_tree_arbiter #(.NUM_REQ(4),  .MODE(0)) u_a (.clock(clock), .reset(rst), .bus(if_a));
  rps_tree_arbiter #(.NUM_REQ(4),  .MODE(1)) u_b (.clock(clock), .reset(rst), .bus(if_b));
  rps_tree_arbiter #(.NUM_REQ(2),  .MODE(0)) u_c (.clock(clock), .reset(rst), .bus(if_c));
  rps_tree_arbiter #(.NUM_REQ(16), .MODE(1)) u_d (.clock(clock), .reset(rst), .bus(if_d));

  // One edge of the arbiter as the rules describe it: scan lines from ptr upward.
  function automatic mst_t mstep(int n, int mode, logic [15:0] rq, logic en,
                                 logic lk, logic rs, mst_t s);
    mst_t t = s;
    int   w = -1;
    if (rs) begin
      t.ptr = 0; t.id = 0; t.vld = 1'b0;
      return t;
    end
    if (!en) begin
      t.vld = 1'b0; t.id = 0;
      if (mode == 0) t.ptr = (s.ptr + 1) % n;
      return t;
    end
    if (s.vld && lk && rq[s.id]) return t;
    for (int k = 0; k < n; k++) begin
      if (w < 0 && rq[(s.ptr + k) % n]) w = (s.ptr + k) % n;
    end
    if (w >= 0) begin
      t.vld = 1'b1; t.id = w;
      t.ptr = (mode == 0) ? (s.ptr + 1) % n : (w + 1) % n;
    end else begin
      t.vld = 1'b0; t.id = 0;
      if (mode == 0) t.ptr = (s.ptr + 1) % n;
    end
    return t;
  endfunction

  always @(posedge clock) begin
    ms0 <= mstep(4,  0, 16'(r0), en0, lk0, rst, ms0);
    ms1 <= mstep(4,  1, 16'(r1), en1, lk1, rst, ms1);
    ms2 <= mstep(2,  0, 16'(r2), en2, lk2, rst, ms2);
    ms3 <= mstep(16, 1, r3,      en3, lk3, rst, ms3);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string tag, input mst_t s, input logic [15:0] rq,
                            input logic [15:0] g, input logic [31:0] gid, input logic v,
                            input logic ru, input logic [31:0] cnt);
    logic [15:0] eg;
    eg = s.vld ? (16'(1) << s.id) : 16'(0);
    chk({tag, " gnt"},    32'(g),   32'(eg));
    chk({tag, " gnt_id"}, gid,      32'(s.id));
    chk({tag, " valid"},  32'(v),   32'(s.vld));
    chk({tag, " count"},  cnt,      32'(s.ptr));
    chk({tag, " req_up"}, 32'(ru),  32'(|rq));
    chk({tag, " inv"},    32'($onehot0(g) && (v == |g)), 32'(1));
  endtask

  // Every cycle, away from the active edge, all four arbiters against the model.
  always @(negedge clock) begin
    if (armed) begin
      check_inst("a", ms0, 16'(r0), 16'(if_a.gnt), 32'(if_a.gnt_id), if_a.valid, if_a.req_up, 32'(if_a.count));
      check_inst("b", ms1, 16'(r1), 16'(if_b.gnt), 32'(if_b.gnt_id), if_b.valid, if_b.req_up, 32'(if_b.count));
      check_inst("c", ms2, 16'(r2), 16'(if_c.gnt), 32'(if_c.gnt_id), if_c.valid, if_c.req_up, 32'(if_c.count));
      check_inst("d", ms3, r3,      if_d.gnt,      32'(if_d.gnt_id), if_d.valid, if_d.req_up, 32'(if_d.count));
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Random traffic for the 2-way and 16-way instances.
  initial begin
    r2 = '0; en2 = 1'b0; lk2 = 1'b0;
    r3 = '0; en3 = 1'b0; lk3 = 1'b0;
    forever begin
      tick;
      r2  = 2'($urandom);
      en2 = ($urandom_range(0, 7) != 0);
      lk2 = 1'($urandom_range(0, 1));
      r3  = 16'($urandom) & 16'($urandom);
      en3 = ($urandom_range(0, 7) != 0);
      lk3 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [3:0] ga[4];
    int         ca[4], ib[4], vb[4], cb[4];
    ga = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ca = '{1, 2, 3, 0};
    ib = '{1, 3, 1, 0};
    vb = '{1, 1, 1, 0};
    cb = '{2, 0, 2, 2};

    rst = 1'b1;
    en0 = 1'b0; lk0 = 1'b0; r0 = '0;
    en1 = 1'b0; lk1 = 1'b0; r1 = '0;
    tick; tick;
    armed = 1'b1;
    chk("rst gnt a",   32'(if_a.gnt),   0);
    chk("rst count a", 32'(if_a.count), 0);
    chk("rst valid b", 32'(if_b.valid), 0);

    // Free-running rotation on a, round-robin on b.
    rst = 1'b0;
    en0 = 1'b1; r0 = 4'b1111;
    en1 = 1'b1; r1 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) r1 = 4'b0000;
      tick;
      chk("rot gnt a",   32'(if_a.gnt),    32'(ga[k]));
      chk("rot count a", 32'(if_a.count),  32'(ca[k]));
      chk("rr id b",     32'(if_b.gnt_id), 32'(ib[k]));
      chk("rr valid b",  32'(if_b.valid),  32'(vb[k]));
      chk("rr count b",  32'(if_b.count),  32'(cb[k]));
    end

    // a: en dropped while locked on line 3; b: grant line 1.
    lk0 = 1'b1; en0 = 1'b0; r1 = 4'b0010;
    tick;
    chk("en0 gnt a",   32'(if_a.gnt),   0);
    chk("en0 valid a", 32'(if_a.valid), 0);
    chk("en0 count a", 32'(if_a.count), 1);
    chk("first gnt b", 32'(if_b.gnt),   32'(4'b0010));
    chk("first cnt b", 32'(if_b.count), 2);

    en0 = 1'b1; r1 = 4'b0110; lk1 = 1'b1;
    tick;
    chk("reen gnt a",   32'(if_a.gnt),   32'(4'b0010));
    chk("reen count a", 32'(if_a.count), 2);
    chk("hold gnt b",   32'(if_b.gnt),   32'(4'b0010));
    chk("hold cnt b",   32'(if_b.count), 2);

    lk0 = 1'b0; r0 = 4'b0000;
    repeat (4) begin
      tick;
      chk("hold gnt b", 32'(if_b.gnt),   32'(4'b0010));
      chk("hold cnt b", 32'(if_b.count), 2);
    end

    lk1 = 1'b0;
    tick;
    chk("unlock gnt b", 32'(if_b.gnt),   32'(4'b0100));
    chk("unlock cnt b", 32'(if_b.count), 3);

    // Holder drops its request under lock: next line granted at once.
    r1 = 4'b0010;
    tick;
    chk("regrant gnt b", 32'(if_b.gnt),   32'(4'b0010));
    chk("regrant cnt b", 32'(if_b.count), 2);
    lk1 = 1'b1; r1 = 4'b0110;
    tick;
    chk("relock gnt b", 32'(if_b.gnt), 32'(4'b0010));
    r1 = 4'b0100;
    tick;
    chk("drop gnt b", 32'(if_b.gnt),   32'(4'b0100));
    chk("drop cnt b", 32'(if_b.count), 3);

    // Reset while b holds line 2 locked.
    rst = 1'b1;
    #1;
    chk("rst req_up b", 32'(if_b.req_up), 1);
    tick;
    chk("mrst gnt b",    32'(if_b.gnt),    0);
    chk("mrst id b",     32'(if_b.gnt_id), 0);
    chk("mrst valid b",  32'(if_b.valid),  0);
    chk("mrst count b",  32'(if_b.count),  0);
    chk("mrst req_up b", 32'(if_b.req_up), 1);
    chk("mrst count a",  32'(if_a.count),  0);
    rst = 1'b0; lk1 = 1'b0;
    tick;
    chk("post gnt b",   32'(if_b.gnt),   32'(4'b0100));
    chk("post cnt b",   32'(if_b.count), 3);
    chk("post count a", 32'(if_a.count), 1);

    repeat (3000) tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rps_tree_arbiter.md
Name: rps_tree_arbiter

Overview:
- Parametrised N-way rotating-priority arbiter and successor to the fixed 4-way rotating-priority selector.
- Arbitrates NUM_REQ request lines and produces a registered one-hot grant, encoded grant index and aggregate request-up.
- Two priority-rotation modes: free-running count or round-robin after last winner.
- Grant lock allows a winner to hold the resource for multi-cycle transactions. Sits between requesting masters and a shared resource; req_up allows cascading into a higher-level arbiter.

Parameters:
NUM_REQ, 8, number of requesters; power of 2, >= 2
MODE, 0, 0 = priority pointer free-runs every cycle; 1 = round-robin, pointer moves past last winner
IDW, $clog2(NUM_REQ), width of index/pointer (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  request lines, bit i = requester i
en  in  1  arbitration enable; 0 forces no grant
lock  in  1  current grant holder requests to keep grant
gnt  out  NUM_REQ  registered one-hot grant (or all zero)
gnt_id  out  IDW  registered binary index of granted line; 0 when no grant
valid  out  1  registered; 1 iff gnt != 0
req_up  out  1  combinational OR of req (independent of en)
count  out  IDW  current priority pointer ptr (registered)

Behaviour:
- Reset (sync, highest precedence): gnt=0, gnt_id=0, valid=0, ptr=0. req_up still follows req.
- Priority order: requester ptr is highest, then ptr+1, ptr+2 ... wrapping modulo NUM_REQ. The winner is the first asserted req in that order.
- Latency: the grant decision uses req/ptr sampled at edge k and appears on gnt/gnt_id/valid after edge k; one cycle.
- Per edge, evaluated in order:
  1. en=0: gnt<=0, valid<=0, gnt_id<=0. Any lock is broken.
  2. Hold condition is valid=1 & lock=1 & req[gnt_id]=1: outputs unchanged; ptr frozen in both modes.
  3. Otherwise, with any req set: gnt<=onehot(winner), gnt_id<=winner, valid<=1.
  4. Otherwise: gnt<=0, valid<=0, gnt_id<=0.
- Pointer update when not held (cases 1, 3, 4):
  - MODE 0: ptr<=ptr+1, wrapping NUM_REQ-1 -> 0. Advances even with en=0 or no requests.
  - MODE 1: after a new grant in case 3, ptr<=winner+1 (wrapping). Otherwise ptr is unchanged.
- Lock release:
  - Occurs when lock drops or the holder drops its req while lock=1.
  - Normal arbitration happens at that same edge; no idle cycle is inserted.
  - The released holder may win again only if priority order selects it.
- lock with valid=0 has no effect.
- lock is not qualified per requester; the integrating logic drives lock on behalf of the current holder.
- Invariants:
  - gnt is always one-hot or zero.
  - valid == |gnt.
  - gnt_id matches the gnt bit position.
  - gnt bit i set implies req[i] was set at the deciding edge.
- Simultaneous requests: exactly one grant, chosen by pointer order.
- Reset mid-lock: clears the grant and ptr at that edge. Arbitration resumes the next edge with ptr=0.
- The implementation may use a log2(NUM_REQ)-level tree of 2-input priority selectors or a flat scheme. Only cycle behaviour is normative.

Test Plan:
- NUM_REQ=4, MODE=0: reset, en=1, req=4'b1111 held for 4 cycles. Expect gnt=0001, 0010, 0100, 1000, and count=0,1,2,3,0.
- NUM_REQ=4, MODE=1: reset, req=4'b1010 held. Expect gnt_id=1 then 3 then 1 (ptr=2,0,2). Then req=0 for 1 cycle: gnt=0, valid=0, ptr unchanged at 2.
- Lock hold: MODE=1, req=4'b0110 with lock=1 after the first grant to line 1. gnt stays 0010 for 5 cycles and count stays 2. Drop lock: next edge gnt=0100.
- Holder drops req under lock: gnt=0010, lock=1, req goes 0110->0100. Next edge gnt=0100; no empty cycle.
- en=0 mid-lock: gnt=1000, lock=1, en=0 for one cycle. Expect gnt=0 and valid=0, and in MODE 0 count still advances. Re-enable: arbitration restarts from the updated ptr.
- Reset mid-operation: assert reset while gnt=0100. Next edge gnt=0, gnt_id=0, count=0, with req_up=1 throughout while req!=0. Also run NUM_REQ=2 and 16 with random req/lock/en, checking the invariants every cycle.
